// File: rtl/tl_pkg.sv
// Shared types and helpers for the parametrised traffic-light controller family.
// Holds the phase encodings and the one-hot lamp decoder used by the top level.
package tl_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } tl_state_t;

    localparam int MAX_ROADS = 32;
    localparam int MAX_IDX_W = 5;

    // Wide one-hot so any road count up to MAX_ROADS can truncate it.
    function automatic logic [MAX_ROADS-1:0] lamp_onehot(input logic [MAX_IDX_W-1:0] idx);
        return {{(MAX_ROADS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Round-robin road picker: first road after cur_road (cyclically) with its sensor set,
// or simply the next road when nobody else is waiting. Purely combinational.
module tl_rr_pick #(
    parameter int N_ROADS = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_ROADS-1:0] sensor,
    input  logic [IDX_W-1:0]   cur_road,
    output logic [IDX_W-1:0]   pick_road
);

    localparam int JW = IDX_W + 1;

    logic [JW-1:0] nxt1;
    logic [JW-1:0] j;

    // Descending scan lets the closest waiting road overwrite the farther ones.
    always_comb begin
        nxt1 = {1'b0, cur_road} + JW'(1);
        if (nxt1 >= JW'(N_ROADS)) begin
            nxt1 = nxt1 - JW'(N_ROADS);
        end
        pick_road = nxt1[IDX_W-1:0];
        j = '0;
        for (int k = N_ROADS - 1; k >= 1; k--) begin
            j = {1'b0, cur_road} + JW'(k);
            if (j >= JW'(N_ROADS)) begin
                j = j - JW'(N_ROADS);
            end
            if (|(sensor & (N_ROADS'(1) << j))) begin
                pick_road = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tl_cntr_param.sv
// Parametrised N-road traffic-light controller with sensors, minimum green and round-robin.
// Define TL_ALLRED_EN to insert an all-red clearance phase between yellow and the next green.
module tl_cntr_param
    import tl_pkg::*;
#(
    parameter int N_ROADS    = 4,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = 4,
    parameter int GREEN_MIN  = 4,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_ROADS-1:0] sensor,
    output logic [N_ROADS-1:0] light_g,
    output logic [N_ROADS-1:0] light_y,
    output logic [N_ROADS-1:0] light_r,
    output logic [IDX_W-1:0]   cur_road,
    output logic               switch_p
);

    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYC - 1);
`ifdef TL_ALLRED_EN
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_CYC - 1);
`endif

    if (N_ROADS < 2 || N_ROADS > MAX_ROADS || IDX_W > MAX_IDX_W || (1 << IDX_W) < N_ROADS ||
        GREEN_MIN < 1 || GREEN_MIN > (1 << CNT_W) || YELLOW_CYC < 1 || YELLOW_CYC > (1 << CNT_W) ||
        ALLRED_CYC < 1 || ALLRED_CYC > (1 << CNT_W)) begin : g_bad_params
        $error("tl_cntr_param: parameter set out of range");
    end

    tl_state_t            state;
    tl_state_t            state_nxt;
    logic [IDX_W-1:0]     nxt_road;
    logic [IDX_W-1:0]     pick_road;
    logic [CNT_W-1:0]     cnt;
    logic                 cur_sensor;
    logic                 green_done;
    logic                 from_phase;
    logic [N_ROADS-1:0]   sel;

    assign cur_sensor = |(sensor & (N_ROADS'(1) << cur_road));
    assign green_done = (cnt == G_LAST) && !cur_sensor;
    assign from_phase = (state == ST_YELLOW)
`ifdef TL_ALLRED_EN
                        || (state == ST_ALLRED)
`endif
                        ;

    tl_rr_pick #(
        .N_ROADS (N_ROADS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .sensor    (sensor),
        .cur_road  (cur_road),
        .pick_road (pick_road)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_GREEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Unused encodings fall through to default and recover to green.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_GREEN: begin
                if (green_done) begin
                    state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (cnt == Y_LAST) begin
`ifdef TL_ALLRED_EN
                    state_nxt = ST_ALLRED;
`else
                    state_nxt = ST_GREEN;
`endif
                end
            end
`ifdef TL_ALLRED_EN
            ST_ALLRED: begin
                if (cnt == A_LAST) begin
                    state_nxt = ST_GREEN;
                end
            end
`endif
            default: state_nxt = ST_GREEN;
        endcase
    end

    // Sensors only matter at the green exit; nxt_road stays frozen afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            cur_road <= '0;
            nxt_road <= '0;
            switch_p <= 1'b0;
        end else begin
            switch_p <= (state_nxt == ST_GREEN) && (state != ST_GREEN);
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (!((state == ST_GREEN) && (cnt == G_LAST))) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == ST_GREEN) && green_done) begin
                nxt_road <= pick_road;
            end
            if ((state_nxt == ST_GREEN) && (state != ST_GREEN)) begin
                cur_road <= from_phase ? nxt_road : '0;
            end
        end
    end

    assign sel = N_ROADS'(lamp_onehot(MAX_IDX_W'(cur_road)));

    always_comb begin
        light_g = '0;
        light_y = '0;
        light_r = '1;
        case (state)
            ST_GREEN: begin
                light_g = sel;
                light_r = ~sel;
            end
            ST_YELLOW: begin
                light_y = sel;
                light_r = ~sel;
            end
            default: begin
                light_r = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_tl_cntr_param.sv
// Directed bench for tl_cntr_param: a default 4-road instance and a legacy 2-road instance.
// Expectations adapt to TL_ALLRED_EN by inserting the all-red cycles.
module tb_tl_cntr_param;

`ifdef TL_ALLRED_EN
    localparam int AR_MAIN = 2;
    localparam int AR_LEG  = 1;
`else
    localparam int AR_MAIN = 0;
    localparam int AR_LEG  = 0;
`endif

    logic       clk = 1'b0;
    bit         run = 1'b0;
    logic       reset_n;
    logic       reset_n_leg;
    logic [3:0] sensor;
    logic [1:0] sensor_leg;

    logic [3:0] light_g, light_y, light_r;
    logic [1:0] cur_road;
    logic       switch_p;
    logic [1:0] leg_g, leg_y, leg_r;
    logic [0:0] leg_road;
    logic       leg_switch;

    int checks = 0;
    int errors = 0;

    always begin
        #5;
        if (run) clk = ~clk;
    end

    tl_cntr_param #(
        .N_ROADS(4), .IDX_W(2), .CNT_W(4), .GREEN_MIN(4), .YELLOW_CYC(2), .ALLRED_CYC(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sensor(sensor),
        .light_g(light_g), .light_y(light_y), .light_r(light_r),
        .cur_road(cur_road), .switch_p(switch_p)
    );

    tl_cntr_param #(
        .N_ROADS(2), .IDX_W(1), .CNT_W(4), .GREEN_MIN(1), .YELLOW_CYC(1), .ALLRED_CYC(1)
    ) dut_leg (
        .clk(clk), .reset_n(reset_n_leg), .sensor(sensor_leg),
        .light_g(leg_g), .light_y(leg_y), .light_r(leg_r),
        .cur_road(leg_road), .switch_p(leg_switch)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkMain(input string tag, input logic [3:0] g, input logic [3:0] y,
                             input logic [3:0] r, input logic [1:0] road, input logic sw);
        checkOutput({tag, ".g"}, 32'(light_g), 32'(g));
        checkOutput({tag, ".y"}, 32'(light_y), 32'(y));
        checkOutput({tag, ".r"}, 32'(light_r), 32'(r));
        checkOutput({tag, ".road"}, 32'(cur_road), 32'(road));
        checkOutput({tag, ".sw"}, 32'(switch_p), 32'(sw));
    endtask

    task automatic checkLeg(input string tag, input logic [1:0] g, input logic [1:0] y,
                            input logic [1:0] r, input logic road, input logic sw);
        checkOutput({tag, ".g"}, 32'(leg_g), 32'(g));
        checkOutput({tag, ".y"}, 32'(leg_y), 32'(y));
        checkOutput({tag, ".r"}, 32'(leg_r), 32'(r));
        checkOutput({tag, ".road"}, 32'(leg_road), 32'(road));
        checkOutput({tag, ".sw"}, 32'(leg_switch), 32'(sw));
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic [1:0] sl);
        sensor     = s;
        sensor_leg = sl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b1;
        reset_n_leg = 1'b1;
        sensor      = 4'b0000;
        sensor_leg  = 2'b00;
        #2;
        reset_n     = 1'b0;
        reset_n_leg = 1'b0;
        #1;
        checkMain("reset", 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0);
        checkLeg("reset_leg", 2'b01, 2'b00, 2'b10, 1'b0, 1'b0);

        run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Minimum green: four green cycles, two yellow, then road 1.
        checkMain("g0_c1", 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 2'b00);
            checkMain("g0_hold", 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b0000, 2'b00);
            checkMain("y0", 4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b0);
        end
        for (int i = 0; i < AR_MAIN; i++) begin
            applyStimulus(4'b0000, 2'b00);
            checkMain("ar0", 4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0);
        end
        applyStimulus(4'b1001, 2'b00);
        checkMain("g1_entry", 4'b0010, 4'b0000, 4'b1101, 2'd1, 1'b1);

        // Round-robin skip to road 3; sensor changes after the exit are ignored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1001, 2'b00);
            checkMain("g1_hold", 4'b0010, 4'b0000, 4'b1101, 2'd1, 1'b0);
        end
        applyStimulus(4'b1001, 2'b00);
        checkMain("y1_a", 4'b0000, 4'b0010, 4'b1101, 2'd1, 1'b0);
        applyStimulus(4'b0100, 2'b00);
        checkMain("y1_b", 4'b0000, 4'b0010, 4'b1101, 2'd1, 1'b0);
        for (int i = 0; i < AR_MAIN; i++) begin
            applyStimulus(4'b0110, 2'b00);
            checkMain("ar1", 4'b0000, 4'b0000, 4'b1111, 2'd1, 1'b0);
        end
        applyStimulus(4'b0100, 2'b00);
        checkMain("g3_entry", 4'b1000, 4'b0000, 4'b0111, 2'd3, 1'b1);

        // Road 3 holds green while its sensor stays high, then wraps to road 0.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b1001, 2'b00);
            checkMain("g3_hold", 4'b1000, 4'b0000, 4'b0111, 2'd3, 1'b0);
        end
        applyStimulus(4'b0001, 2'b00);
        checkMain("y3_a", 4'b0000, 4'b1000, 4'b0111, 2'd3, 1'b0);
        applyStimulus(4'b0001, 2'b00);
        checkMain("y3_b", 4'b0000, 4'b1000, 4'b0111, 2'd3, 1'b0);
        for (int i = 0; i < AR_MAIN; i++) begin
            applyStimulus(4'b0001, 2'b00);
            checkMain("ar3", 4'b0000, 4'b0000, 4'b1111, 2'd3, 1'b0);
        end
        applyStimulus(4'b0001, 2'b00);
        checkMain("g0_wrap", 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b1);

        // Road 0 hands over to road 2, skipping idle road 1.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0100, 2'b00);
            checkMain("g0_hold2", 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0);
        end
        for (int i = 0; i < 2 + AR_MAIN; i++) begin
            applyStimulus(4'b0100, 2'b00);
        end
        applyStimulus(4'b0000, 2'b00);
        checkMain("g2_entry", 4'b0100, 4'b0000, 4'b1011, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 2'b00);
        end
        applyStimulus(4'b0000, 2'b00);
        checkMain("y2", 4'b0000, 4'b0100, 4'b1011, 2'd2, 1'b0);

        // Asynchronous reset in the middle of yellow, between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        checkMain("async_rst", 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0);
        #1;
        reset_n = 1'b1;
        #1;
        checkMain("post_rst", 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 2'b00);
            checkMain("post_rst_g", 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0);
        end
        applyStimulus(4'b0000, 2'b00);
        checkMain("post_rst_y", 4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b0);

        // Legacy two-road A/B sequence.
        reset_n_leg = 1'b1;
        sensor_leg  = 2'b01;
        checkLeg("leg_g0", 2'b01, 2'b00, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 2'b01);
            checkLeg("leg_g0_hold", 2'b01, 2'b00, 2'b10, 1'b0, 1'b0);
        end
        applyStimulus(4'b0000, 2'b00);
        checkLeg("leg_y0", 2'b00, 2'b01, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < AR_LEG; i++) begin
            applyStimulus(4'b0000, 2'b00);
            checkLeg("leg_ar0", 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        end
        applyStimulus(4'b0000, 2'b00);
        checkLeg("leg_g1", 2'b10, 2'b00, 2'b01, 1'b1, 1'b1);
        applyStimulus(4'b0000, 2'b00);
        checkLeg("leg_y1", 2'b00, 2'b10, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < AR_LEG; i++) begin
            applyStimulus(4'b0000, 2'b00);
            checkLeg("leg_ar1", 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
        end
        applyStimulus(4'b0000, 2'b00);
        checkLeg("leg_g0_again", 2'b01, 2'b00, 2'b10, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tl_cntr_param.md
Name: tl_cntr_param

Overview:
Parametrised traffic-light controller for N_ROADS approaches sharing one intersection. It is the successor to the fixed 2-road, 2-bit next-state controller, and adds:
- per-road traffic sensors;
- a programmable minimum-green time and yellow duration;
- round-robin selection of the next road to get green.

It sits between the sensor inputs and the lamp drivers. With N_ROADS=2, GREEN_MIN=1 and YELLOW_CYC=1 it reproduces the legacy A/B sequence exactly.

Parameters:
N_ROADS, 4, number of approaches; must be at least 2.
IDX_W, 2, width of the road index; must satisfy 2^IDX_W >= N_ROADS.
CNT_W, 4, phase-timer width.
GREEN_MIN, 4, minimum green length in cycles (1..2^CNT_W).
YELLOW_CYC, 2, yellow length in cycles (1..2^CNT_W).
ALLRED_CYC, 1, all-red length in cycles; used only with TL_ALLRED_EN.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
sensor  in  N_ROADS  bit i set means traffic is waiting or present on road i
light_g  out  N_ROADS  green lamp per road
light_y  out  N_ROADS  yellow lamp per road
light_r  out  N_ROADS  red lamp per road
cur_road  out  IDX_W  index of the road currently owning green or yellow
switch_p  out  1  one-cycle pulse in the first cycle of each new green

Behaviour:
- Registers: state (2 bits), cur_road, nxt_road, cnt (CNT_W), switch_p. reset_n low clears them all immediately, with no clock needed:
  - state=GREEN, cur_road=0, cnt=0, switch_p=0.
  - Outputs after reset: light_g = one-hot bit 0, light_r = all other bits, light_y = 0.
- Lamps are Moore-decoded from the registers only:
  - GREEN: g[cur_road]=1, all other roads red.
  - YELLOW: y[cur_road]=1, all other roads red.
  - ALLRED: all roads red.
  - Exactly one lamp is lit per road at all times.
- cnt clears on every state entry and increments each cycle. In GREEN it saturates at GREEN_MIN-1.
- GREEN exit:
  - Condition: cnt==GREEN_MIN-1 AND sensor[cur_road]==0.
  - Action on the next edge: state becomes YELLOW, and nxt_road latches the pick result.
  - Otherwise the state holds, so green persists indefinitely while sensor[cur_road]=1.
- Pick rule:
  - Scan j = cur_road+1, cur_road+2, … modulo N_ROADS, excluding cur_road; the first j with sensor[j]=1 wins.
  - If no other road has sensor set, pick (cur_road+1) mod N_ROADS. This preserves legacy behaviour.
  - Wrap-around: a scan from N_ROADS-1 continues at 0.
- YELLOW: lasts exactly YELLOW_CYC cycles. On the edge where cnt==YELLOW_CYC-1, go to GREEN with cur_road<=nxt_road, or to ALLRED if the macro is enabled.
- Entering GREEN from another state sets switch_p=1 for that single cycle. It is 0 otherwise, including out of reset.
- Sensors are sampled only at the GREEN-exit decision. Sensor changes during YELLOW or ALLRED are ignored; nxt_road is frozen.
- Reset asserted mid-phase aborts immediately to the reset state.
- Unused state encodings recover to GREEN with cur_road=0 on the next edge.

Optional Feature:
TL_ALLRED_EN.
- Defined: YELLOW exits to ALLRED, holds for ALLRED_CYC cycles with all lamps red, then goes to GREEN on nxt_road.
- Undefined: ALLRED state, its timer compare and the ALLRED_CYC usage are not compiled; YELLOW goes directly to GREEN.

Decomposition:
- Package tl_pkg:
  - state encodings ST_GREEN=2'b00, ST_YELLOW=2'b01, ST_ALLRED=2'b10;
  - a helper function computing one-hot lamp vectors from an index.
- Sub-module tl_rr_pick: purely combinational; inputs sensor, cur_road; output pick_road. Reused by future lane controllers.

Test Plan:
- Reset: default params, reset_n low with no clock running -> light_g=4'b0001, light_r=4'b1110, light_y=0, cur_road=0, switch_p=0.
- Legacy mode (N_ROADS=2, GREEN_MIN=1, YELLOW_CYC=1), sensor=2'b01 held then cleared to 2'b00 -> next cycle light_y=2'b01; following cycle light_g=2'b10, switch_p=1, cur_road=1.
- Minimum green (N_ROADS=4, GREEN_MIN=4), sensor=0 from release of reset -> green on road 0 for exactly 4 cycles, then YELLOW for 2 cycles, then green on road 1.
- Round-robin skip: road 1 green, sensor=4'b1001 at exit -> YELLOW on road 1, then green on road 3. Then, with sensor=4'b0001 at road 3's exit -> wraps to green on road 0.
- TL_ALLRED_EN defined (YELLOW_CYC=2, ALLRED_CYC=2): sequence G…, Y, Y, R, R, then G on the new road. Sensor toggled during R does not change the new road.
- Async reset mid-YELLOW on road 2 -> lamps return to road-0 green within the same timestep, with no clock edge. After release, normal operation resumes from cnt=0.
